// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-master memory arbiter.
// slave  : arbiter view (accepts master requests, drives the shared bus).
// master : environment view (drives requests, models the memory slave).
interface mem_arbiter_if;
    logic        m0_valid;
    logic        m0_ready;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic        m1_ready;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;

    logic [1:0]  grant;
    logic        timeout_irq;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  s_ready, s_rdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        output grant, timeout_irq
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output s_ready, s_rdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        input  grant, timeout_irq
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus (m0 = CPU, m1 = DMA).
// Every transaction passes through IDLE, so ownership can only change between
// transactions. Optional watchdog: define MEM_ARBITER_TIMEOUT_EN to abort a
// grant after TIMEOUT_CYCLES cycles without s_ready.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;       // 1 = m1 was granted last
    logic        w_last_nxt;
    logic [1:0]  r_grant;

    logic        w_sel1;
    logic        w_own;
    logic        w_valid;
    logic        w_to;

    assign w_sel1  = (r_state == GNT1);
    assign w_own   = (r_state != IDLE);
    assign w_valid = w_sel1 ? bus.m1_valid : bus.m0_valid;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wd;

    // Watchdog: zero while idle, counts granted cycles that lack s_ready.
    always_ff @(posedge clk) begin
        if (!resetn || !w_own) r_wd <= '0;
        else if (!bus.s_ready) r_wd <= r_wd + 16'd1;
    end

    // Abort on the granted cycle that would be the TIMEOUT_CYCLES-th without
    // s_ready; a late s_ready or a dropped request wins over the abort.
    assign w_to = w_own && w_valid && !bus.s_ready && (r_wd == TO_LAST);
`else
    logic w_unused_param;
    assign w_unused_param = (TIMEOUT_CYCLES != 0);
    assign w_to = 1'b0;
`endif

    assign bus.timeout_irq = w_to;
    assign bus.grant       = r_grant;

    // State, last-owner and registered grant decode.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_nxt;
            r_grant <= {w_next == GNT1, w_next == GNT0};
        end
    end

    // Next-state logic plus owner-routed bus muxing.
    always_comb begin
        w_next       = r_state;
        w_last_nxt   = r_last;
        bus.s_valid  = 1'b0;
        bus.s_addr   = '0;
        bus.s_wdata  = '0;
        bus.s_wstrb  = '0;
        bus.m0_ready = 1'b0;
        bus.m0_rdata = '0;
        bus.m1_ready = 1'b0;
        bus.m1_rdata = '0;
        case (r_state)
            IDLE: begin
                if (bus.m0_valid && (!bus.m1_valid || r_last)) w_next = GNT0;
                else if (bus.m1_valid)                         w_next = GNT1;
            end
            GNT0, GNT1: begin
                bus.s_valid = w_valid && !w_to;
                bus.s_addr  = w_sel1 ? bus.m1_addr  : bus.m0_addr;
                bus.s_wdata = w_sel1 ? bus.m1_wdata : bus.m0_wdata;
                bus.s_wstrb = w_sel1 ? bus.m1_wstrb : bus.m0_wstrb;
                if (w_sel1) begin
                    bus.m1_ready = bus.s_ready || w_to;
                    bus.m1_rdata = w_to ? 32'h0 : bus.s_rdata;
                end else begin
                    bus.m0_ready = bus.s_ready || w_to;
                    bus.m0_rdata = w_to ? 32'h0 : bus.s_rdata;
                end
                if (bus.s_ready || w_to) begin
                    w_next     = IDLE;
                    w_last_nxt = w_sel1;
                end else if (!w_valid) begin
                    w_next = IDLE;    // requester gave up: drop silently
                end
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of granted cycles without s_ready before the watchdog aborts (valid range 2..65535).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 m0_valid  input  1  master 0 (CPU) request; held high until m0_ready.
REQ-005 m0_ready  output  1  master 0 transfer complete, one-cycle pulse.
REQ-006 m0_addr / m0_wdata  input  32 each  master 0 address / write data.
REQ-007 m0_wstrb  input  4  master 0 byte write strobes; 0 = read.
REQ-008 m0_rdata  output  32  master 0 read data, valid when m0_ready.
REQ-009 m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same widths and meanings for master 1 (DMA).
REQ-010 s_valid  output  1  request to shared memory bus.
REQ-011 s_ready  input  1  completion from the decoded slave.
REQ-012 s_addr / s_wdata  output  32 each; s_wstrb  output  4; s_rdata  input  32.
REQ-013 grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 0 when idle.
REQ-014 timeout_irq  output  1  one-cycle pulse on watchdog abort.

Function
REQ-015 FSM states: IDLE, GNT0, GNT1; grant is the registered one-hot state decode.
REQ-016 IDLE -> GNT0 when only m0_valid; IDLE -> GNT1 when only m1_valid; both -> master not granted last (round-robin); after reset, last-granted is m1, so m0 wins the first tie.
REQ-017 Arbitration latency: exactly one cycle from valid seen in IDLE to s_valid high.
REQ-018 In GNTx, s_valid/s_addr/s_wdata/s_wstrb equal master x's inputs combinationally; in IDLE s_valid=0, s_wstrb=0, s_addr=0, s_wdata=0.
REQ-019 In GNTx, mx_ready = s_ready and mx_rdata = s_rdata combinationally; the non-owner sees ready=0, rdata=0.
REQ-020 GNTx -> IDLE on the cycle after s_ready; last-granted updated to x at that edge.
REQ-021 GNTx -> IDLE if master x drops valid before s_ready (protocol violation); no ready is issued.
REQ-022 No ownership change mid-transaction; the second requester waits with ready low, no starvation beyond one transaction.
REQ-023 Minimum transaction cost: 2 cycles (IDLE + grant); back-to-back same-master requests each re-arbitrate through IDLE.

Reset
REQ-024 While resetn=0 at a clock edge: state=IDLE, grant=0, last-granted=m1, watchdog counter=0, timeout_irq=0.
REQ-025 Reset mid-transaction aborts silently: no ready pulse, s_valid low from the next cycle.
REQ-026 All outputs are 0 during and after reset until a request is granted.

Configuration
REQ-027 Macro MEM_ARBITER_TIMEOUT_EN compiles in a 16-bit watchdog counter.
REQ-028 With it: counter clears on entering GNTx, increments each granted cycle without s_ready; when it reaches TIMEOUT_CYCLES, mx_ready=1 and mx_rdata=32'h0 for that cycle, s_valid=0 for that cycle, timeout_irq=1 for that cycle, then IDLE.
REQ-029 s_ready arriving on the abort cycle takes precedence: normal completion, no timeout_irq.
REQ-030 Without it: no counter, grant held indefinitely until s_ready, timeout_irq tied 0.

Verification
REQ-031 m0 read at 0x0000_0100, slave s_ready 1 cycle after s_valid with rdata 0xDEADBEEF -> grant=01, m0_ready pulse, m0_rdata=0xDEADBEEF, total 3 cycles from m0_valid.
REQ-032 m0 and m1 assert valid in same cycle just after reset -> m0 served first, then m1; next simultaneous request -> m1 first.
REQ-033 m1 write 0x12345678 wstrb 4'b0011 while m0 requests mid-transaction -> s_wstrb=0011 only during GNT1, m0 waits, then is granted.
REQ-034 resetn low while GNT1 waiting on s_ready -> no m1_ready, grant=0, s_valid=0 next cycle.
REQ-035 With MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never ready -> m0_ready=1, m0_rdata=0, timeout_irq=1 on 4th granted cycle, then IDLE; without macro, grant stays 01 for 100 cycles.
